// File: rtl/scroll_message_controller.sv
// Scroll controller feeding the 28-bit display register: keeps a 16-character
// message and reloads the whole 4-digit window on each scroll tick.
module scroll_message_controller #(
  parameter int DIV     = 50000000,
  parameter int MSG_MAX = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [6:0]  wr_data,
  input  logic [3:0]  msg_len,
  input  logic [1:0]  mode,
  input  logic        start,
  input  logic        stop,
  output logic        load,
  output logic [1:0]  s,
  output logic [27:0] d,
  output logic        m_sig,
  output logic        busy,
  output logic [3:0]  pos,
  output logic        wrap
);

  localparam int CW = (DIV > 2) ? $clog2(DIV - 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 2);
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_LEFT   = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      pos_q, pos_d;
  logic [4:0]      len_q, len_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  logic [27:0]     d_q;
  logic [6:0]      mem_q [MSG_MAX];
  logic            enterLoad;
  logic [27:0]     window;
  logic [3:0]      idx;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    len_d     = len_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    enterLoad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && mode != 2'b00) begin
          state_d   = LOAD;
          pos_d     = '0;
          len_d     = {1'b0, msg_len} + 5'd1;
          mode_d    = mode;
          enterLoad = 1'b1;
        end
      end
      LOAD: begin
        if (stop || mode_q == MODE_STATIC) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == TERM) begin
          state_d   = LOAD;
          enterLoad = 1'b1;
          if (mode_q == MODE_LEFT) begin
            wrap_d = ({1'b0, pos_q} + 5'd1 == len_q);
            pos_d  = wrap_d ? 4'd0 : pos_q + 4'd1;
          end else begin
            wrap_d = (pos_q == 4'd0);
            pos_d  = wrap_d ? 4'(len_q - 5'd1) : pos_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window is built from the pre-write memory contents, so a same-cycle write shows up one load later.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 4'((5'(pos_d) + 5'(k)) % len_d);
      window[27-7*k -: 7] = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      pos_q   <= '0;
      len_q   <= 5'd1;
      mode_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      if (enterLoad) d_q <= window;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < MSG_MAX; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign load  = (state_q == LOAD);
  assign busy  = (state_q != IDLE);
  assign wrap  = wrap_q;
  assign pos   = pos_q;
  assign d     = d_q;
  assign s     = 2'b00;
  assign m_sig = 1'b0;

endmodule

// File: tb/tb_scroll_message_controller.sv
// Directed bench for scroll_message_controller with DIV=4 and hand-computed windows.
module tb_scroll_message_controller;

  localparam int DIV = 4;

  logic        clk;
  logic        clr;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [6:0]  wrData;
  logic [3:0]  msgLen;
  logic [1:0]  mode;
  logic        start;
  logic        stop;
  logic        load;
  logic [1:0]  s;
  logic [27:0] d;
  logic        mSig;
  logic        busy;
  logic [3:0]  pos;
  logic        wrap;

  int testsRun = 0;
  int failCount = 0;
  int loadsSeen;
  logic [27:0] leftExp [7];

  scroll_message_controller #(.DIV(DIV), .MSG_MAX(16)) dut (
    .clk(clk), .clr(clr), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .msg_len(msgLen), .mode(mode), .start(start), .stop(stop),
    .load(load), .s(s), .d(d), .m_sig(mSig), .busy(busy), .pos(pos), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] win(input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] c, input logic [6:0] e);
    return {a, b, c, e};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] len, input logic [1:0] md);
    msgLen = len;
    mode   = md;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic nextLoad(input bit pulseStart);
    for (int i = 1; i < DIV; i++) begin
      if (pulseStart && i == 1) begin
        start  = 1'b1;
        mode   = 2'b11;
        msgLen = 4'd0;
      end
      tick();
      start = 1'b0;
      checkOutput("gapNoLoad", {31'b0, load}, 32'd1 - 32'd1);
    end
    tick();
    checkOutput("loadPulse", {31'b0, load}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    msgLen = '0; mode = '0; start = 1'b0; stop = 1'b0;
    leftExp[0] = win(7'h01, 7'h02, 7'h03, 7'h04);
    leftExp[1] = win(7'h02, 7'h03, 7'h04, 7'h05);
    leftExp[2] = win(7'h03, 7'h04, 7'h05, 7'h06);
    leftExp[3] = win(7'h04, 7'h05, 7'h06, 7'h01);
    leftExp[4] = win(7'h05, 7'h06, 7'h01, 7'h02);
    leftExp[5] = win(7'h06, 7'h01, 7'h02, 7'h03);
    leftExp[6] = win(7'h01, 7'h02, 7'h03, 7'h04);

    tick(); tick();
    clr = 1'b1;
    checkOutput("rstLoad", {31'b0, load}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstPos", {28'b0, pos}, 32'd0);
    checkOutput("rstD", {4'b0, d}, 32'd0);
    checkOutput("rstWrap", {31'b0, wrap}, 32'd0);
    checkOutput("rstSM", {29'b0, s, mSig}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      wrEn = 1'b1; wrAddr = 4'(i); wrData = 7'(i + 1);
      tick();
    end
    wrEn = 1'b0;

    // Scroll left through a full wrap, with a start pulse while busy.
    applyStimulus(4'd5, 2'b10);
    checkOutput("leftFirstLoad", {31'b0, load}, 32'd1);
    checkOutput("leftBusy", {31'b0, busy}, 32'd1);
    checkOutput("leftPos0", {28'b0, pos}, 32'd0);
    checkOutput("leftWrap0", {31'b0, wrap}, 32'd0);
    checkOutput("leftD0", {4'b0, d}, {4'b0, leftExp[0]});
    for (int i = 1; i < 7; i++) begin
      nextLoad(i == 3);
      checkOutput("leftPos", {28'b0, pos}, 32'(i % 6));
      checkOutput("leftWrap", {31'b0, wrap}, (i == 6) ? 32'd1 : 32'd0);
      checkOutput("leftD", {4'b0, d}, {4'b0, leftExp[i]});
    end

    // Stop on the terminal-count cycle beats the reload.
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stopNoLoad", {31'b0, load}, 32'd0);
    checkOutput("stopIdle", {31'b0, busy}, 32'd0);
    checkOutput("stopHoldD", {4'b0, d}, {4'b0, win(7'h01, 7'h02, 7'h03, 7'h04)});
    checkOutput("stopHoldPos", {28'b0, pos}, 32'd0);
    loadsSeen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (load) loadsSeen++;
    end
    checkOutput("stopQuiet", 32'(loadsSeen), 32'd0);

    applyStimulus(4'd5, 2'b11);
    checkOutput("rightD0", {4'b0, d}, {4'b0, win(7'h01, 7'h02, 7'h03, 7'h04)});
    checkOutput("rightWrap0", {31'b0, wrap}, 32'd0);
    nextLoad(1'b0);
    checkOutput("rightPos1", {28'b0, pos}, 32'd5);
    checkOutput("rightWrap1", {31'b0, wrap}, 32'd1);
    checkOutput("rightD1", {4'b0, d}, {4'b0, win(7'h06, 7'h01, 7'h02, 7'h03)});
    nextLoad(1'b0);
    checkOutput("rightPos2", {28'b0, pos}, 32'd4);
    checkOutput("rightWrap2", {31'b0, wrap}, 32'd0);
    checkOutput("rightD2", {4'b0, d}, {4'b0, win(7'h05, 7'h06, 7'h01, 7'h02)});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stopLoadBusy", {31'b0, busy}, 32'd0);
    checkOutput("stopLoadPos", {28'b0, pos}, 32'd4);
    checkOutput("stopLoadD", {4'b0, d}, {4'b0, win(7'h05, 7'h06, 7'h01, 7'h02)});

    applyStimulus(4'd5, 2'b01);
    checkOutput("staticLoad", {31'b0, load}, 32'd1);
    checkOutput("staticD", {4'b0, d}, {4'b0, win(7'h01, 7'h02, 7'h03, 7'h04)});
    tick();
    checkOutput("staticBusyFall", {31'b0, busy}, 32'd0);
    loadsSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load) loadsSeen++;
    end
    checkOutput("staticOneShot", 32'(loadsSeen), 32'd0);

    applyStimulus(4'd5, 2'b00);
    checkOutput("haltBusy", {31'b0, busy}, 32'd0);
    checkOutput("haltLoad", {31'b0, load}, 32'd0);

    // Two-character message repeats inside the window.
    applyStimulus(4'd1, 2'b10);
    checkOutput("shortD0", {4'b0, d}, {4'b0, win(7'h01, 7'h02, 7'h01, 7'h02)});
    nextLoad(1'b0);
    checkOutput("shortPos1", {28'b0, pos}, 32'd1);
    checkOutput("shortD1", {4'b0, d}, {4'b0, win(7'h02, 7'h01, 7'h02, 7'h01)});
    nextLoad(1'b0);
    checkOutput("shortWrap", {31'b0, wrap}, 32'd1);
    checkOutput("shortPos2", {28'b0, pos}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    applyStimulus(4'd0, 2'b01);
    checkOutput("singleD", {4'b0, d}, {4'b0, win(7'h01, 7'h01, 7'h01, 7'h01)});
    tick();

    // Write lands in the same cycle the pos=1 window is built.
    applyStimulus(4'd5, 2'b10);
    tick(); tick(); tick();
    wrEn = 1'b1; wrAddr = 4'd4; wrData = 7'h7F;
    tick();
    wrEn = 1'b0;
    checkOutput("editLoad", {31'b0, load}, 32'd1);
    checkOutput("editPos1", {28'b0, pos}, 32'd1);
    checkOutput("editOldD", {4'b0, d}, {4'b0, win(7'h02, 7'h03, 7'h04, 7'h05)});
    nextLoad(1'b0);
    checkOutput("editNewD", {4'b0, d}, {4'b0, win(7'h03, 7'h04, 7'h7F, 7'h06)});

    tick();
    clr = 1'b0;
    tick(); tick();
    clr = 1'b1;
    checkOutput("midRstLoad", {31'b0, load}, 32'd0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    checkOutput("midRstPos", {28'b0, pos}, 32'd0);
    checkOutput("midRstD", {4'b0, d}, 32'd0);
    applyStimulus(4'd5, 2'b01);
    checkOutput("memClearedLoad", {31'b0, load}, 32'd1);
    checkOutput("memClearedD", {4'b0, d}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
